// File: rtl/lane_mux_pkg.sv
// Shared encodings and defaults for the lane serializer (lane_mux_n and its helpers).
package lane_mux_pkg;

    typedef enum logic {
        MODE_FIXED   = 1'b0,
        MODE_COMPACT = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int MAX_LANES     = 16;
    localparam int IDLE_WORD_DEF = 0;

endpackage

// File: rtl/lane_mux_prio.sv
// Lowest set bit of vec at or above start. Purely combinational, no flow control.
module lane_mux_prio #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] start,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int W = $clog2(N);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Descending scan so the lowest qualifying lane is the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i] && (i >= int'(start))) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lane_mux_n.sv
// Serializes lane groups to one word per cycle; first slot 1 cycle after accept, grp_ready low while pending full.
// Optional LANE_MUX_PARITY_EN adds a registered even-parity output par_out.
module lane_mux_n
    import lane_mux_pkg::*;
#(
    parameter int                NUM_LANES = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_WORD_DEF)
) (
    input  logic                          clk_f,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          grp_valid,
    output logic                          grp_ready,
    input  logic [NUM_LANES*DATA_W-1:0]   data_in,
    input  logic [NUM_LANES-1:0]          valid_in,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid_out,
    output logic [$clog2(NUM_LANES)-1:0]  lane_out,
    output logic                          busy
`ifdef LANE_MUX_PARITY_EN
    ,
    output logic                          par_out
`endif
);
    localparam int LW = $clog2(NUM_LANES);

    state_e                      state, state_nxt;
    logic [NUM_LANES*DATA_W-1:0] act_dat, pend_dat;
    logic [NUM_LANES-1:0]        act_vld, pend_vld;
    logic                        act_mode, pend_mode, pend_full, rdy_en;
    logic [LW-1:0]               idx, cur_lane, prio_idx, nxt_lane;
    logic                        prio_found, slot_vld, last, more;
    logic                        accept, slot_go, act_free, nxt_vld;
    logic [DATA_W-1:0]           nxt_dat;

    assign grp_ready = rdy_en && !pend_full;
    assign accept    = grp_valid && grp_ready;
    assign slot_go   = (state == ST_SHIFT);
    assign busy      = slot_go;

    lane_mux_prio #(.N(NUM_LANES)) u_prio (
        .vec   (act_vld),
        .start (idx),
        .idx   (prio_idx),
        .found (prio_found)
    );

    always_comb begin
        more = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (act_vld[i] && (i > int'(prio_idx))) more = 1'b1;
        end
        if (act_mode == MODE_COMPACT) begin
            cur_lane = prio_idx;
            slot_vld = prio_found;
            last     = !prio_found || !more;
        end else begin
            cur_lane = idx;
            slot_vld = act_vld[idx];
            last     = (idx == LW'(NUM_LANES - 1));
        end
        act_free = !slot_go || last;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last && !pend_full && !accept) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_vld  = slot_go && slot_vld;
        nxt_dat  = nxt_vld ? act_dat[int'(cur_lane)*DATA_W +: DATA_W] : IDLE_WORD;
        nxt_lane = (slot_go && ((act_mode == MODE_FIXED) || slot_vld)) ? cur_lane : '0;
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            rdy_en    <= 1'b0;
            act_dat   <= '0;
            act_vld   <= '0;
            act_mode  <= 1'b0;
            pend_dat  <= '0;
            pend_vld  <= '0;
            pend_mode <= 1'b0;
            pend_full <= 1'b0;
            idx       <= '0;
            data_out  <= IDLE_WORD;
            valid_out <= 1'b0;
            lane_out  <= '0;
        end else begin
            rdy_en    <= 1'b1;
            data_out  <= nxt_dat;
            valid_out <= nxt_vld;
            lane_out  <= nxt_lane;
            if (slot_go) idx <= last ? '0 : cur_lane + 1'b1;
            // A group arriving on the last slot with pending empty goes straight to active: no bubble.
            if (act_free) begin
                if (pend_full) begin
                    act_dat   <= pend_dat;
                    act_vld   <= pend_vld;
                    act_mode  <= pend_mode;
                    pend_full <= 1'b0;
                end else if (accept) begin
                    act_dat  <= data_in;
                    act_vld  <= valid_in;
                    act_mode <= mode;
                end
            end else if (accept) begin
                pend_dat  <= data_in;
                pend_vld  <= valid_in;
                pend_mode <= mode;
                pend_full <= 1'b1;
            end
        end
    end

`ifdef LANE_MUX_PARITY_EN
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) par_out <= 1'b0;
        else       par_out <= nxt_vld ? ^nxt_dat : 1'b0;
    end
`endif

endmodule

// File: tb/tb_lane_mux_n.sv
// Directed bench for lane_mux_n with hand-computed slot sequences.
module tb_lane_mux_n;

    logic        clk_f = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        grp_valid = 1'b0;
    logic        grp_ready;
    logic [31:0] data_in = '0;
    logic [3:0]  valid_in = '0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_out;
    logic        busy;
`ifdef LANE_MUX_PARITY_EN
    logic        par_out;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk_f = ~clk_f;

    lane_mux_n #(.NUM_LANES(4), .DATA_W(8), .IDLE_WORD(8'h00)) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .mode      (mode),
        .grp_valid (grp_valid),
        .grp_ready (grp_ready),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .busy      (busy)
`ifdef LANE_MUX_PARITY_EN
        ,
        .par_out   (par_out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; offers one group for one edge and returns at the next negedge.
    task automatic send(input string tag, input logic m, input logic [31:0] d, input logic [3:0] v);
        chk({tag, ".rdy"}, 32'(grp_ready), 32'd1);
        mode      = m;
        data_in   = d;
        valid_in  = v;
        grp_valid = 1'b1;
        @(negedge clk_f);
        grp_valid = 1'b0;
    endtask

    task automatic expect_slot(input string tag, input logic [7:0] d, input logic v, input logic [1:0] l);
        @(negedge clk_f);
        chk({tag, ".dat"},  32'(data_out),  32'(d));
        chk({tag, ".vld"},  32'(valid_out), 32'(v));
        chk({tag, ".lane"}, 32'(lane_out),  32'(l));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst.rdy",  32'(grp_ready), 32'd0);
        chk("rst.busy", 32'(busy),      32'd0);
        chk("rst.vld",  32'(valid_out), 32'd0);
        chk("rst.dat",  32'(data_out),  32'd0);
        chk("rst.lane", 32'(lane_out),  32'd0);
        @(negedge clk_f);
        reset = 1'b0;
        #1 chk("rel.rdy_before_edge", 32'(grp_ready), 32'd0);
        @(negedge clk_f);
        chk("rel.rdy_after_edge", 32'(grp_ready), 32'd1);

        // Fixed mode, all lanes valid
        send("fx1", 1'b0, 32'hCC_DD_EE_FF, 4'b1111);
        chk("fx1.busy", 32'(busy), 32'd1);
        chk("fx1.lat",  32'(valid_out), 32'd0);
        expect_slot("fx1.s0", 8'hFF, 1'b1, 2'd0);
        expect_slot("fx1.s1", 8'hEE, 1'b1, 2'd1);
        expect_slot("fx1.s2", 8'hDD, 1'b1, 2'd2);
        expect_slot("fx1.s3", 8'hCC, 1'b1, 2'd3);
        expect_slot("fx1.end", 8'h00, 1'b0, 2'd0);
        chk("fx1.idle_busy", 32'(busy), 32'd0);

        // Fixed mode, only lane 2 valid
        send("fx2", 1'b0, 32'h66_77_DE_EA, 4'b0100);
        expect_slot("fx2.s0", 8'h00, 1'b0, 2'd0);
        expect_slot("fx2.s1", 8'h00, 1'b0, 2'd1);
        expect_slot("fx2.s2", 8'h77, 1'b1, 2'd2);
        expect_slot("fx2.s3", 8'h00, 1'b0, 2'd3);
        expect_slot("fx2.end", 8'h00, 1'b0, 2'd0);

        // Compact mode, lanes 0 and 2
        send("cp1", 1'b1, 32'h22_33_20_15, 4'b0101);
        expect_slot("cp1.s0", 8'h15, 1'b1, 2'd0);
        expect_slot("cp1.s1", 8'h33, 1'b1, 2'd2);
        expect_slot("cp1.end", 8'h00, 1'b0, 2'd0);
        chk("cp1.busy", 32'(busy), 32'd0);

        // Compact mode, no valid lanes: one busy cycle, no slot
        send("cp0", 1'b1, 32'h12_34_56_78, 4'b0000);
        chk("cp0.busy", 32'(busy), 32'd1);
        expect_slot("cp0.s", 8'h00, 1'b0, 2'd0);
        chk("cp0.busy_after", 32'(busy), 32'd0);

        // Back-to-back fixed groups, no bubble at the transfer
        mode = 1'b0; valid_in = 4'b1111;
        data_in = 32'h88_99_AA_BB; grp_valid = 1'b1;
        @(negedge clk_f);
        chk("b2b.rdy_a", 32'(grp_ready), 32'd1);
        data_in = 32'h11_22_21_16;
        @(negedge clk_f);
        grp_valid = 1'b0;
        chk("b2b.s0.dat", 32'(data_out), 32'hBB);
        chk("b2b.s0.vld", 32'(valid_out), 32'd1);
        chk("b2b.rdy0", 32'(grp_ready), 32'd0);
        expect_slot("b2b.s1", 8'hAA, 1'b1, 2'd1);
        chk("b2b.rdy1", 32'(grp_ready), 32'd0);
        expect_slot("b2b.s2", 8'h99, 1'b1, 2'd2);
        chk("b2b.rdy2", 32'(grp_ready), 32'd0);
        expect_slot("b2b.s3", 8'h88, 1'b1, 2'd3);
        chk("b2b.rdy3", 32'(grp_ready), 32'd1);
        expect_slot("b2b.s4", 8'h16, 1'b1, 2'd0);
        expect_slot("b2b.s5", 8'h21, 1'b1, 2'd1);
        expect_slot("b2b.s6", 8'h22, 1'b1, 2'd2);
        expect_slot("b2b.s7", 8'h11, 1'b1, 2'd3);
        expect_slot("b2b.end", 8'h00, 1'b0, 2'd0);

        // Reset in the middle of a group
        send("mr", 1'b0, 32'hCC_DD_EE_FF, 4'b1111);
        expect_slot("mr.s0", 8'hFF, 1'b1, 2'd0);
        expect_slot("mr.s1", 8'hEE, 1'b1, 2'd1);
        reset = 1'b1;
        #1;
        chk("mr.vld",  32'(valid_out), 32'd0);
        chk("mr.dat",  32'(data_out),  32'd0);
        chk("mr.busy", 32'(busy),      32'd0);
        chk("mr.rdy",  32'(grp_ready), 32'd0);
        @(negedge clk_f);
        @(negedge clk_f);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_slot("mr.post", 8'h00, 1'b0, 2'd0);
        end
        chk("mr.rdy_after", 32'(grp_ready), 32'd1);

`ifdef LANE_MUX_PARITY_EN
        send("par", 1'b1, 32'h00_00_03_07, 4'b0011);
        @(negedge clk_f);
        chk("par.07", 32'(par_out), 32'd1);
        @(negedge clk_f);
        chk("par.03", 32'(par_out), 32'd0);
        @(negedge clk_f);
        chk("par.idle", 32'(par_out), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lane_mux_n.md
LANE_MUX_N -- requirements
Module: lane_mux_n

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of input lanes (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, width of each lane word.
REQ-003 SHALL have parameter IDLE_WORD, default 0, value driven on data_out in an empty or invalid slot.
REQ-004 SHALL have port clk_f, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1, slot mode: 0 = fixed (every lane gets a slot), 1 = compact (invalid lanes skipped); sampled at group acceptance.
REQ-007 SHALL have port grp_valid, input, 1, a lane group is offered.
REQ-008 SHALL have port grp_ready, output, 1, the block can accept a group this cycle.
REQ-009 SHALL have port data_in, input, NUM_LANES*DATA_W, lane words; lane i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port valid_in, input, NUM_LANES, per-lane valid.
REQ-011 SHALL have port data_out, output, DATA_W, serialized word (registered).
REQ-012 SHALL have port valid_out, output, 1, data_out carries a valid lane word (registered).
REQ-013 SHALL have port lane_out, output, $clog2(NUM_LANES), source lane of the current slot (registered).
REQ-014 SHALL have port busy, output, 1, the active buffer holds an unfinished group.

Function
REQ-015 SHALL accept a group on a rising edge where grp_valid && grp_ready, capturing data_in, valid_in and mode.
REQ-016 SHALL hold two group buffers: active (being serialized) and pending; grp_ready = !pending_full.
REQ-017 SHALL load an accepted group into active when active is empty, else into pending.
REQ-018 SHALL emit the first slot of a group loaded into an empty active buffer on the edge after acceptance (latency 1 cycle).
REQ-019 SHALL, in fixed mode, emit exactly NUM_LANES slots in lane order 0..NUM_LANES-1, one per cycle; valid_out = lane valid; data_out = lane word if valid, else IDLE_WORD.
REQ-020 SHALL, in compact mode, emit only valid lanes in ascending lane order, one per cycle.
REQ-021 SHALL, in compact mode, retire a group with valid_in all zero in one cycle with no valid_out.
REQ-022 SHALL, on the cycle the last slot of active is emitted with pending full, move pending to active so the next group's first slot follows with no bubble.
REQ-023 SHALL allow acceptance into pending in the same cycle as that transfer (grp_ready is computed before the transfer).
REQ-024 SHALL drive valid_out=0, data_out=IDLE_WORD, lane_out=0 in any cycle with no slot.
REQ-025 SHALL use state machine IDLE (active empty) -> SHIFT (serializing) -> IDLE on last slot with pending empty, or SHIFT -> SHIFT on last slot with pending full.

Reset
REQ-026 SHALL, while reset is high, clear both buffers, the slot counter and state (IDLE).
REQ-027 SHALL, while reset is high, drive grp_ready=0, busy=0, valid_out=0, data_out=IDLE_WORD, lane_out=0.
REQ-028 SHALL discard any group in flight when reset asserts mid-group; no partial slot follows deassertion.
REQ-029 SHALL assert grp_ready on the first edge after reset deasserts.

Configuration
REQ-030 SHALL, with LANE_MUX_PARITY_EN defined, add output par_out (1 bit, registered): even parity over data_out, 0 when valid_out=0.
REQ-031 SHALL, without LANE_MUX_PARITY_EN, have no par_out port and no parity logic.

Structure
REQ-032 SHALL place the mode encoding (MODE_FIXED, MODE_COMPACT), MAX_LANES=16 and the default IDLE_WORD in shared package lane_mux_pkg.
REQ-033 SHALL implement the compact-mode next-valid-lane search as sub-module lane_mux_prio (find first set bit at or above the current index).

Verification
REQ-034 SHALL pass: fixed mode, data FF,EE,DD,CC (lanes 0..3), valid 1111 -> FF,EE,DD,CC with lane_out 0..3, valid_out=1 on 4 consecutive cycles.
REQ-035 SHALL pass: fixed mode, data EA,DE,77,66, valid 0100 -> slots 00(v0),00(v0),77(v1),00(v0).
REQ-036 SHALL pass: compact mode, data 15,20,33,22, valid 0101 -> 15 (lane 0) then 33 (lane 2), 2 cycles, then valid_out=0.
REQ-037 SHALL pass: two groups BB,AA,99,88 then 16,21,22,11 offered back-to-back in fixed mode -> 8 consecutive valid slots, grp_ready low from the second acceptance until the transfer edge.
REQ-038 SHALL pass: reset asserted after the 2nd slot of group FF,EE,DD,CC -> outputs cleared asynchronously, no DD/CC emitted after release.
REQ-039 SHALL pass: with LANE_MUX_PARITY_EN, slot 07 -> par_out=1, slot 03 -> par_out=0.
